// File: rtl/sram_bus_regfile.sv
// sram_bus_regfile: slave on an asynchronous SRAM-style processor bus. The
// strobes are synchronised, a small register bank is decoded with read-back,
// and LED_N LEDs are driven off, static or blinking from a free-running counter.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-low
//   ncs        bus chip select, active-low, asynchronous
//   nwe        bus write strobe, active-low, asynchronous
//   nrd        bus read strobe, active-low, asynchronous
//   addr       bus address, asynchronous
//   sram_data  bidirectional bus data, driven only during an accepted read
//   led        registered LED outputs
//
// Register map (index = addr[IDX_W-1:0]):
//   0 CTRL   bit0 EN, bit1 BLINK, bit2 CLR (clears counter, reads 0)
//   1 LEDVAL static LED value / blink mask
//   2 DIVSEL blink counter bit select, clamped to CNT_W-1
//   3..NREGS-2 scratch
//   NREGS-1 ID (read-only, returns VERSION)
//
// Optional feature, macro SRAM_BUS_WRCNT_EN: register NREGS-2 becomes a
// read-only count of committed in-range writes.

module sram_bus_regfile #(
    parameter int unsigned          ADDR_W    = 13,
    parameter int unsigned          DATA_W    = 8,
    parameter int unsigned          NREGS     = 8,
    parameter int unsigned          LED_N     = 4,
    parameter int unsigned          CNT_W     = 25,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter logic [DATA_W-1:0]    VERSION   = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ncs,
    input  logic              nwe,
    input  logic              nrd,
    input  logic [ADDR_W-1:0] addr,
    inout  logic [DATA_W-1:0] sram_data,
    output logic [LED_N-1:0]  led
);

    localparam int unsigned IDX_W = $clog2(NREGS);
    localparam int unsigned SEL_W = $clog2(CNT_W);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    // Synchronisers; idle-high so a reset never looks like an access.
    logic              ncs_m_q, sncs_q, nwe_m_q, snwe_q, nrd_m_q, snrd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_hit_q, wr_hit_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              oe_q, oe_d;

    logic [1:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] ledval_q, ledval_d;
    logic [DATA_W-1:0] divsel_q, divsel_d;
    logic [DATA_W-1:0] scratch_q [NREGS];
    logic [DATA_W-1:0] scratch_d [NREGS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LED_N-1:0]  led_q, led_d;
`ifdef SRAM_BUS_WRCNT_EN
    logic [DATA_W-1:0] wrcnt_q, wrcnt_d;
`endif

    logic              hit;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rdata;
    logic              commit;
    logic [SEL_W-1:0]  sel;
    logic              blink_bit;
    logic              oe;

    // Reset gates the driver directly so the bus is released without waiting
    // for the next clock edge.
    assign oe        = oe_q & reset;
    assign sram_data = oe ? rd_q : 'z;
    assign led       = led_q;

    always_comb begin
        hit = (addr_q[ADDR_W-1:IDX_W] == BASE_ADDR[ADDR_W-1:IDX_W]);
        idx = addr_q[IDX_W-1:0];

        rdata = scratch_q[idx];
        if (idx == '0) begin
            rdata = {{(DATA_W-2){1'b0}}, ctrl_q};
        end else if (idx == IDX_W'(1)) begin
            rdata = ledval_q;
        end else if (idx == IDX_W'(2)) begin
            rdata = divsel_q;
        end else if (idx == IDX_W'(NREGS-1)) begin
            rdata = VERSION;
`ifdef SRAM_BUS_WRCNT_EN
        end else if (idx == IDX_W'(NREGS-2)) begin
            rdata = wrcnt_q;
`endif
        end
    end

    // Bus FSM next state.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        wr_hit_d  = wr_hit_q;
        rd_d      = rd_q;
        oe_d      = oe_q;
        commit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!sncs_q && !snwe_q) begin
                    state_d   = StWr;
                    wr_idx_d  = idx;
                    wr_data_d = data_q;
                    wr_hit_d  = hit;
                end else if (!sncs_q && !snrd_q) begin
                    state_d = StRd;
                    rd_d    = hit ? rdata : '0;
                    oe_d    = 1'b1;
                end
            end
            StWr: begin
                if (snwe_q || sncs_q) begin
                    // Commit what was captured while the strobe was still low.
                    state_d = StIdle;
                    commit  = wr_hit_q;
                end else begin
                    wr_idx_d  = idx;
                    wr_data_d = data_q;
                    wr_hit_d  = hit;
                end
            end
            StRd: begin
                if (snrd_q || sncs_q) begin
                    state_d = StIdle;
                    oe_d    = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                oe_d    = 1'b0;
            end
        endcase
    end

    // Register bank, counter and LED next state.
    always_comb begin
        ctrl_d    = ctrl_q;
        ledval_d  = ledval_q;
        divsel_d  = divsel_q;
        scratch_d = scratch_q;
        // A CLR write overrides the increment, including on the wrap cycle.
        cnt_d     = cnt_q + 1'b1;
`ifdef SRAM_BUS_WRCNT_EN
        wrcnt_d   = commit ? wrcnt_q + 1'b1 : wrcnt_q;
`endif
        if (commit) begin
            if (wr_idx_q == '0) begin
                ctrl_d = wr_data_q[1:0];
                if (wr_data_q[2]) begin
                    cnt_d = '0;
                end
            end else if (wr_idx_q == IDX_W'(1)) begin
                ledval_d = wr_data_q;
            end else if (wr_idx_q == IDX_W'(2)) begin
                divsel_d = wr_data_q;
            end else if (wr_idx_q == IDX_W'(NREGS-1)) begin
                // ID is read-only.
`ifdef SRAM_BUS_WRCNT_EN
            end else if (wr_idx_q == IDX_W'(NREGS-2)) begin
                // WRCNT is read-only; the write is still counted above.
`endif
            end else begin
                scratch_d[wr_idx_q] = wr_data_q;
            end
        end

        if (32'(divsel_q) >= CNT_W - 1) begin
            sel = SEL_W'(CNT_W - 1);
        end else begin
            sel = SEL_W'(divsel_q);
        end
        blink_bit = cnt_q[sel];

        if (!ctrl_q[0]) begin
            led_d = '0;
        end else if (ctrl_q[1]) begin
            led_d = ledval_q[LED_N-1:0] & {LED_N{blink_bit}};
        end else begin
            led_d = ledval_q[LED_N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ncs_m_q   <= 1'b1;
            sncs_q    <= 1'b1;
            nwe_m_q   <= 1'b1;
            snwe_q    <= 1'b1;
            nrd_m_q   <= 1'b1;
            snrd_q    <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            state_q   <= StIdle;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            wr_hit_q  <= 1'b0;
            rd_q      <= '0;
            oe_q      <= 1'b0;
            ctrl_q    <= 2'b11;
            ledval_q  <= '1;
            divsel_q  <= DATA_W'(CNT_W - 1);
            for (int i = 0; i < NREGS; i++) begin
                scratch_q[i] <= '0;
            end
            cnt_q     <= '0;
            led_q     <= '1;
`ifdef SRAM_BUS_WRCNT_EN
            wrcnt_q   <= '0;
`endif
        end else begin
            ncs_m_q   <= ncs;
            sncs_q    <= ncs_m_q;
            nwe_m_q   <= nwe;
            snwe_q    <= nwe_m_q;
            nrd_m_q   <= nrd;
            snrd_q    <= nrd_m_q;
            addr_q    <= addr;
            data_q    <= sram_data;
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            wr_hit_q  <= wr_hit_d;
            rd_q      <= rd_d;
            oe_q      <= oe_d;
            ctrl_q    <= ctrl_d;
            ledval_q  <= ledval_d;
            divsel_q  <= divsel_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
`ifdef SRAM_BUS_WRCNT_EN
            wrcnt_q   <= wrcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_bus_regfile.sv
// Directed testbench for sram_bus_regfile. Read expectations are queued when
// a read is issued and popped when the data is due on the bus.

module tb_sram_bus_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        ncs, nwe, nrd;
    logic [12:0] addr;
    logic [7:0]  tb_wdata;
    logic        tb_oe;
    wire  [7:0]  sram_data;
    logic [3:0]  led;

    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        oe_seen = 1'b0;

    assign sram_data = tb_oe ? tb_wdata : 'z;

    sram_bus_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .ncs       (ncs),
        .nwe       (nwe),
        .nrd       (nrd),
        .addr      (addr),
        .sram_data (sram_data),
        .led       (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en && dut.oe) begin
            oe_seen <= 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        addr     = a;
        tb_wdata = d;
        tb_oe    = 1'b1;
        ncs      = 1'b0;
        nwe      = 1'b0;
        repeat (4) @(negedge clk);
        nwe = 1'b1;
        ncs = 1'b1;
        repeat (3) @(negedge clk);
        tb_oe = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [12:0] a, input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        addr = a;
        ncs  = 1'b0;
        nrd  = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "_oe_early"}, 32'(dut.oe), 32'd0);
        @(negedge clk);
        e = exp_q.pop_front();
        check({name, "_oe"}, 32'(dut.oe), 32'd1);
        check({name, "_data"}, 32'(sram_data), 32'(e));
        @(negedge clk);
        nrd = 1'b1;
        ncs = 1'b1;
        repeat (2) @(negedge clk);
        check({name, "_hold"}, 32'(sram_data), 32'(e));
        @(negedge clk);
        check({name, "_oe_off"}, 32'(dut.oe), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        ncs      = 1'b1;
        nwe      = 1'b1;
        nrd      = 1'b1;
        addr     = '0;
        tb_wdata = '0;
        tb_oe    = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_led", 32'(led), 32'hF);
        check("rst_oe", 32'(dut.oe), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_led_blink_low", 32'(led), 32'h0);
        bus_read("ctrl_rst", 13'h0, 8'h03);
        bus_read("id_rst", 13'h7, 8'hA5);
        bus_read("ledval_rst", 13'h1, 8'hFF);
        bus_read("divsel_rst", 13'h2, 8'd24);

        // Static LED mode.
        bus_write(13'h1, 8'h5A);
        bus_write(13'h0, 8'h01);
        @(negedge clk);
        check("led_static", 32'(led), 32'hA);
        bus_read("ledval_5a", 13'h1, 8'h5A);
        bus_read("ctrl_static", 13'h0, 8'h01);

        // Blink on counter bit 3, counter cleared by CLR.
        bus_write(13'h1, 8'hFF);
        bus_write(13'h2, 8'h03);
        bus_write(13'h0, 8'h07);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            check("led_blink", 32'(led), (((i - 1) >> 3) & 1) != 0 ? 32'hF : 32'h0);
        end
        bus_read("ctrl_clr_reads0", 13'h0, 8'h03);

        // DIVSEL beyond the counter clamps to the top bit, which is still low.
        bus_write(13'h2, 8'd200);
        repeat (3) @(negedge clk);
        check("led_clamp", 32'(led), 32'h0);
        bus_read("divsel_200", 13'h2, 8'd200);

        // Both strobes low: the write wins and the bus is never driven.
        @(negedge clk);
        oe_seen  = 1'b0;
        mon_en   = 1'b1;
        addr     = 13'h3;
        tb_wdata = 8'h77;
        tb_oe    = 1'b1;
        ncs      = 1'b0;
        nwe      = 1'b0;
        nrd      = 1'b0;
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        nwe = 1'b1;
        nrd = 1'b1;
        repeat (3) @(negedge clk);
        tb_oe = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("wr_rd_no_drive", 32'(oe_seen), 32'd0);
        bus_read("scratch3", 13'h3, 8'h77);

        // Out-of-range and read-only accesses.
        bus_write(13'h0100, 8'h33);
        bus_write(13'h0103, 8'h44);
        bus_read("oor_ledval", 13'h1, 8'hFF);
        bus_read("oor_scratch3", 13'h3, 8'h77);
        bus_read("oor_read", 13'h0100, 8'h00);
        bus_write(13'h7, 8'h12);
        bus_read("id_ro", 13'h7, 8'hA5);

        // Reset in the middle of a read.
        @(negedge clk);
        addr = 13'h3;
        ncs  = 1'b0;
        nrd  = 1'b0;
        repeat (3) @(negedge clk);
        check("midrd_oe", 32'(dut.oe), 32'd1);
        check("midrd_data", 32'(sram_data), 32'h77);
        reset = 1'b0;
        #1;
        check("midrd_rst_oe", 32'(dut.oe), 32'd0);
        repeat (2) @(negedge clk);
        check("midrd_rst_led", 32'(led), 32'hF);
        nrd = 1'b1;
        ncs = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        bus_read("ctrl_rst2", 13'h0, 8'h03);
        bus_read("ledval_rst2", 13'h1, 8'hFF);
        bus_read("divsel_rst2", 13'h2, 8'd24);
        bus_read("scratch3_rst2", 13'h3, 8'h00);

`ifdef SRAM_BUS_WRCNT_EN
        bus_write(13'h3, 8'h11);
        bus_write(13'h6, 8'h99);
        bus_write(13'h0106, 8'h55);
        bus_write(13'h7, 8'h12);
        bus_read("wrcnt_3", 13'h6, 8'h03);
        for (int i = 0; i < 253; i++) begin
            bus_write(13'h4, 8'(i));
        end
        bus_read("wrcnt_wrap", 13'h6, 8'h00);
        bus_read("scratch4", 13'h4, 8'd252);
`else
        bus_write(13'h6, 8'h66);
        bus_read("scratch6", 13'h6, 8'h66);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
